// File: rtl/demux_pack_pkg.sv
// Shared types and constants for the demux_pack symbol-to-word packer.
package demux_pack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int unsigned DEF_IN_W  = 8;
    localparam int unsigned DEF_RATIO = 4;
    localparam int unsigned DEF_CNT_W = 8;

    // Fill-counter width; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/demux_pack_out_reg.sv
// Output holding register for packed words with valid/ready handshake.
module demux_pack_out_reg
    import demux_pack_pkg::*;
#(
    parameter int unsigned W = DEF_IN_W * DEF_RATIO
) (
    input  logic         clk_4f,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_partial,
    input  logic         ready_out,
    output logic [W-1:0] data_out,
    output logic         partial_out,
    output logic         valid_out,
    output logic         ready_in
);

    logic [W-1:0] data_q, data_d;
    logic         partial_q, partial_d;
    logic         valid_q, valid_d;

    // A load only arrives when the register is free or draining, so it wins over drain.
    always_comb begin
        data_d    = data_q;
        partial_d = partial_q;
        valid_d   = valid_q;
        if (load) begin
            data_d    = load_data;
            partial_d = load_partial;
            valid_d   = 1'b1;
        end else if (ready_out) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            data_q    <= '0;
            partial_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            data_q    <= data_d;
            partial_q <= partial_d;
            valid_q   <= valid_d;
        end
    end

    assign ready_in    = reset || !valid_q || ready_out;
    assign data_out    = data_q;
    assign partial_out = partial_q;
    assign valid_out   = valid_q;

endmodule

// File: rtl/demux_pack_param.sv
// Packs RATIO narrow symbols (first symbol in the MSBs) into one wide word.
// Optional macro DEMUX_PACK_FLUSH_EN: an abort emits the padded partial word.
module demux_pack_param
    import demux_pack_pkg::*;
#(
    parameter int unsigned     IN_W  = DEF_IN_W,
    parameter int unsigned     RATIO = DEF_RATIO,
    parameter int unsigned     CNT_W = DEF_CNT_W,
    parameter logic [IN_W-1:0] PAD   = '0
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    input  logic [IN_W-1:0]       data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [IN_W*RATIO-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  partial_out,
    output logic [CNT_W-1:0]      abort_cnt
);

    localparam int unsigned        CW       = cnt_width(RATIO);
    localparam int unsigned        WORD_W   = IN_W * RATIO;
    localparam logic [CW-1:0]      LAST     = CW'(RATIO - 1);
    localparam logic [WORD_W-1:0]  PAD_WORD = {RATIO{PAD}};

    state_e              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [WORD_W-1:0]   buf_q, buf_d, buf_ins;
    logic [CNT_W-1:0]    abort_q, abort_d;

    logic                rdy;
    logic                accept;
    logic                abort;
    logic                load;
    logic                load_partial;
    logic [WORD_W-1:0]   load_data;

    assign accept = !reset && valid_in && rdy;
    assign abort  = !reset && rdy && !valid_in && (count_q != '0);

    // Slots not yet written hold PAD, so a flushed partial word needs no extra fill.
    always_comb begin
        buf_ins = buf_q;
        for (int k = 0; k < int'(RATIO); k++) begin
            if (count_q == CW'(k)) begin
                buf_ins[(int'(RATIO) - 1 - k) * int'(IN_W) +: IN_W] = data_in;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        buf_d        = buf_q;
        abort_d      = abort_q;
        load         = 1'b0;
        load_data    = buf_ins;
        load_partial = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_d   = buf_ins;
                    count_d = CW'(1);
                    state_d = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    if (count_q == LAST) begin
                        load    = 1'b1;
                        buf_d   = PAD_WORD;
                        count_d = '0;
                        state_d = HOLD;
                    end else begin
                        buf_d   = buf_ins;
                        count_d = count_q + CW'(1);
                    end
                end else if (abort) begin
                    if (abort_q != '1) begin
                        abort_d = abort_q + CNT_W'(1);
                    end
                    buf_d   = PAD_WORD;
                    count_d = '0;
`ifdef DEMUX_PACK_FLUSH_EN
                    load         = 1'b1;
                    load_data    = buf_q;
                    load_partial = 1'b1;
                    state_d      = HOLD;
`else
                    state_d      = IDLE;
`endif
                end
            end
            HOLD: begin
                if (ready_out) begin
                    if (accept) begin
                        buf_d   = buf_ins;
                        count_d = CW'(1);
                        state_d = FILL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            buf_q   <= PAD_WORD;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            abort_q <= abort_d;
        end
    end

    demux_pack_out_reg #(
        .W (WORD_W)
    ) u_out_reg (
        .clk_4f       (clk_4f),
        .reset        (reset),
        .load         (load),
        .load_data    (load_data),
        .load_partial (load_partial),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .partial_out  (partial_out),
        .valid_out    (valid_out),
        .ready_in     (rdy)
    );

    assign ready_in  = rdy;
    assign abort_cnt = abort_q;

endmodule

// File: doc/demux_pack_param.md
DEMUX_PACK_PARAM -- requirements
Module: demux_pack_param

Interface
REQ-001 Parameter IN_W, default 8: width of one input symbol, bits; legal range >= 1.
REQ-002 Parameter RATIO, default 4: number of input symbols packed into one output word; legal range >= 2.
REQ-003 Parameter CNT_W, default 8: width of the abort counter.
REQ-004 Parameter PAD, default all-zeros (IN_W bits): fill value for missing symbols in a flushed partial word.
REQ-005 clk_4f  input  1  sole clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  IN_W  input symbol.
REQ-008 valid_in  input  1  data_in carries a symbol.
REQ-009 ready_in  output  1  block accepts a symbol this cycle.
REQ-010 data_out  output  IN_W*RATIO  packed word.
REQ-011 valid_out  output  1  data_out holds a word.
REQ-012 ready_out  input  1  downstream consumes the word this cycle.
REQ-013 partial_out  output  1  qualifies data_out as a padded partial word.
REQ-014 abort_cnt  output  CNT_W  count of abandoned partial words.

Function
REQ-015 A symbol is accepted when valid_in && ready_in are both high in the same cycle.
REQ-016 Packing order is first-accepted symbol in the most-significant IN_W bits: symbol k of a word lands at bits [(RATIO-k)*IN_W-1 : (RATIO-k-1)*IN_W].
REQ-017 Fill counter width is clog2(RATIO); it counts 0..RATIO-1 and wraps to 0 on acceptance of symbol RATIO-1.
REQ-018 On acceptance of symbol RATIO-1, the assembled word shall be registered onto data_out, with valid_out high from the next cycle (latency 1).
REQ-019 Output handshake: the word transfers when valid_out && ready_out; data_out, partial_out and valid_out shall be held stable while valid_out && !ready_out.
REQ-020 ready_in = !valid_out || ready_out; a completing symbol accepted in a cycle when a word drains loads the new word next cycle with valid_out kept high (no bubble).
REQ-021 FSM states: IDLE (count 0, output empty), FILL (count > 0), HOLD (output register occupied).
REQ-021a Transitions: IDLE->FILL on the first accept; FILL->HOLD on the completing accept; HOLD->IDLE on drain with no new accept; HOLD->FILL on drain plus accept; HOLD stays on stall.
REQ-022 Abort event: a cycle with ready_in=1, valid_in=0 and count > 0. Cycles with ready_in=0 are never aborts.
REQ-023 On an abort, without the feature in REQ-028: the partial word is discarded, count returns to 0, and abort_cnt increments, saturating at all-ones.
REQ-024 When valid_in is high on every accepting cycle, the throughput shall be one word per RATIO accepted symbols.

Reset
REQ-025 While reset is high on a clock edge: data_out=0, valid_out=0, partial_out=0, abort_cnt=0, count=0, FSM=IDLE.
REQ-026 While reset is high, ready_in shall read 1, and symbols presented during reset are dropped.
REQ-027 Reset asserted mid-word or during HOLD discards all held data without an abort increment; the first word after reset release starts at symbol 0.

Configuration
REQ-028 Macro DEMUX_PACK_FLUSH_EN.
REQ-028a When DEMUX_PACK_FLUSH_EN is defined, an abort loads the partial word into the output register, with unfilled low symbols set to PAD, partial_out=1, and abort_cnt still incremented.
REQ-028b When DEMUX_PACK_FLUSH_EN is undefined, REQ-023 applies and partial_out is tied to 0.
REQ-029 With DEMUX_PACK_FLUSH_EN defined, a flush shall only occur when ready_in=1 (by REQ-022), so the output register is guaranteed free.

Structure
REQ-030 Package demux_pack_pkg shall hold the FSM state typedef (IDLE/FILL/HOLD), the default-parameter constants and a clog2-based counter-width function.
REQ-031 Sub-module demux_pack_out_reg shall hold the data_out/partial_out/valid_out holding register and the REQ-019/020 handshake; the top-level holds the shifter, counter, FSM and abort logic.

Verification
REQ-032 Defaults; bytes 0xDE,0xAD,0xBE,0xEF with valid_in high and ready_out=1 -> data_out=0xDEADBEEF and valid_out high for exactly 1 cycle, starting 1 cycle after 0xEF.
REQ-033 Continuous stream 0x00..0x0F with ready_out=1 -> words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F back-to-back, with no bubbles.
REQ-034 Word held, ready_out=0 for 5 cycles -> data_out stable and ready_in=0 throughout; the symbol offered is accepted on the cycle ready_out rises.
REQ-035 0x11,0x22 then valid_in=0 for one cycle, flush macro undefined -> no output and abort_cnt=1; with the flush macro defined and PAD=0xBC -> data_out=0x1122BCBC and partial_out=1.
REQ-036 Reset pulsed after 3 symbols -> all outputs 0; next 4 symbols 0xA1..0xA4 -> data_out=0xA1A2A3A4 and abort_cnt=0.
REQ-037 IN_W=10, RATIO=3: symbols 0x3FF,0x000,0x155 -> data_out=30'h3FF00155.
